// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-controller state encoding.
// Default addresses match the MIPS-style memory map used by the core.
package cpu_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 2048;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_addr_chk.sv
// Combinational fetch-address fault detector: flags misaligned PCs and
// PCs outside the instruction-memory window.
module fetch_addr_chk
    import cpu_pkg::*;
#(
    parameter logic [31:0] IM_BASE  = cpu_pkg::IM_BASE,
    parameter int unsigned IM_WORDS = cpu_pkg::IM_WORDS
) (
    input  logic [31:0] pc_i,
    output logic        fault_o
);

    // Address of the last word in the window; compares are unsigned.
    localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

    assign fault_o = (pc_i[1:0] != 2'b00) || (pc_i < IM_BASE) || (pc_i > IM_LAST);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: PC register, next-PC selection, IF/ID slot
// with fetch-fault tagging, and a delivered-fetch counter.
module imem_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = cpu_pkg::PC_RESET,
    parameter logic [31:0] EXC_VEC  = cpu_pkg::EXC_VEC,
    parameter logic [31:0] IM_BASE  = cpu_pkg::IM_BASE,
    parameter int unsigned IM_WORDS = cpu_pkg::IM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        fetch_exc,
    output logic [31:0] bad_addr,
    output logic [31:0] fetch_cnt
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  if_pc_q;
    logic [31:0]  if_instr_q;
    logic         if_valid_q;
    logic         fetch_exc_q;
    logic [31:0]  bad_addr_q;
    logic [31:0]  fetch_cnt_q;
    logic [31:0]  pc_d;
    logic         fault;

    fetch_addr_chk #(
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS)
    ) u_chk (
        .pc_i    (pc_q),
        .fault_o (fault)
    );

    // Sequential successor; a taken branch replaces it but the word fetched
    // this cycle still enters the slot as the delay-slot instruction.
    assign pc_d = br_taken ? br_target : (pc_q + 32'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            pc_q        <= PC_RESET;
            if_pc_q     <= '0;
            if_instr_q  <= '0;
            if_valid_q  <= 1'b0;
            fetch_exc_q <= 1'b0;
            bad_addr_q  <= '0;
            fetch_cnt_q <= '0;
        end else if (exc_req || eret) begin
            state_q     <= ST_RUN;
            pc_q        <= exc_req ? EXC_VEC : epc;
            if_valid_q  <= 1'b0;
            fetch_exc_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                default: begin
                    if (stall) begin
                        state_q <= ST_HOLD;
                    end else begin
                        state_q     <= ST_RUN;
                        pc_q        <= pc_d;
                        if_pc_q     <= pc_q;
                        if_valid_q  <= 1'b1;
                        fetch_cnt_q <= fetch_cnt_q + 32'd1;
                        fetch_exc_q <= fault;
                        if (fault) begin
                            if_instr_q <= '0;
                            bad_addr_q <= pc_q;
                        end else begin
                            if_instr_q <= imem_dout;
                        end
                    end
                end
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_valid  = if_valid_q;
    assign fetch_exc = fetch_exc_q;
    assign bad_addr  = bad_addr_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl; the instruction memory is modelled
// as addr ^ 32'hA5A5_0000 so each fetched word is predictable.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, exc_req, eret;
    logic [31:0] br_target, epc, imem_addr, imem_dout;
    logic [31:0] if_pc, if_instr, bad_addr, fetch_cnt;
    logic        if_valid, fetch_exc;
    int          vec  = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    assign imem_dout = imem_addr ^ 32'hA5A5_0000;

    imem_fetch_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .exc_req   (exc_req),
        .eret      (eret),
        .epc       (epc),
        .imem_addr (imem_addr),
        .imem_dout (imem_dout),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_valid  (if_valid),
        .fetch_exc (fetch_exc),
        .bad_addr  (bad_addr),
        .fetch_cnt (fetch_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; exc_req = 1'b0; eret = 1'b0;
        br_target = '0; epc = '0;
        step();
        step();
        reset = 1'b0;
        vec++; if (imem_addr !== 32'h3000) begin errs++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'h3000); end
        vec++; if (if_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        vec++; if (if_pc !== 32'h0) begin errs++; $display("FAIL rst_ifpc got=%h exp=0", if_pc); end
        vec++; if (if_instr !== 32'h0) begin errs++; $display("FAIL rst_instr got=%h exp=0", if_instr); end
        vec++; if (fetch_exc !== 1'b0 || bad_addr !== 32'h0) begin errs++; $display("FAIL rst_fault got=%b/%h exp=0/0", fetch_exc, bad_addr); end
        vec++; if (fetch_cnt !== 32'h0) begin errs++; $display("FAIL rst_cnt got=%0d exp=0", fetch_cnt); end
    endtask

    task automatic test_boot();
        step();
        vec++; if (imem_addr !== 32'h3000 || if_valid !== 1'b0) begin errs++; $display("FAIL boot_hold got=%h/%b exp=3000/0", imem_addr, if_valid); end
        step();
        vec++; if (imem_addr !== 32'h3004 || if_valid !== 1'b1) begin errs++; $display("FAIL boot_first got=%h/%b exp=3004/1", imem_addr, if_valid); end
        vec++; if (if_pc !== 32'h3000 || if_instr !== 32'hA5A5_3000) begin errs++; $display("FAIL boot_slot got=%h/%h exp=3000/a5a53000", if_pc, if_instr); end
        step();
        vec++; if (imem_addr !== 32'h3008 || if_valid !== 1'b1) begin errs++; $display("FAIL boot_second got=%h/%b exp=3008/1", imem_addr, if_valid); end
        vec++; if (fetch_cnt !== 32'd2) begin errs++; $display("FAIL boot_cnt got=%0d exp=2", fetch_cnt); end
        step();
        step();
        vec++; if (imem_addr !== 32'h3010 || fetch_cnt !== 32'd4) begin errs++; $display("FAIL run_seq got=%h/%0d exp=3010/4", imem_addr, fetch_cnt); end
    endtask

    task automatic test_branch();
        br_taken = 1'b1; br_target = 32'h3100;
        step();
        br_taken = 1'b0;
        vec++; if (if_pc !== 32'h3010 || if_valid !== 1'b1) begin errs++; $display("FAIL br_slot got=%h/%b exp=3010/1", if_pc, if_valid); end
        vec++; if (if_instr !== 32'hA5A5_3010) begin errs++; $display("FAIL br_instr got=%h exp=a5a53010", if_instr); end
        vec++; if (imem_addr !== 32'h3100 || fetch_cnt !== 32'd5) begin errs++; $display("FAIL br_target got=%h/%0d exp=3100/5", imem_addr, fetch_cnt); end
        step();
        vec++; if (if_pc !== 32'h3100 || imem_addr !== 32'h3104) begin errs++; $display("FAIL br_after got=%h/%h exp=3100/3104", if_pc, imem_addr); end
    endtask

    task automatic test_stall();
        br_taken = 1'b1; br_target = 32'h3020;
        step();
        vec++; if (imem_addr !== 32'h3020 || fetch_cnt !== 32'd7) begin errs++; $display("FAIL st_setup got=%h/%0d exp=3020/7", imem_addr, fetch_cnt); end
        stall = 1'b1; br_target = 32'h3200;
        for (int i = 0; i < 3; i++) begin
            step();
            vec++;
            if (imem_addr !== 32'h3020 || if_pc !== 32'h3104 || if_valid !== 1'b1 ||
                if_instr !== 32'hA5A5_3104 || fetch_cnt !== 32'd7 || fetch_exc !== 1'b0) begin
                errs++;
                $display("FAIL st_frozen%0d got=%h/%h/%b/%0d exp=3020/3104/1/7", i, imem_addr, if_pc, if_valid, fetch_cnt);
            end
        end
        stall = 1'b0;
        step();
        br_taken = 1'b0;
        vec++; if (imem_addr !== 32'h3200 || if_pc !== 32'h3020 || fetch_cnt !== 32'd8) begin errs++; $display("FAIL st_release got=%h/%h/%0d exp=3200/3020/8", imem_addr, if_pc, fetch_cnt); end
        step();
        vec++; if (imem_addr !== 32'h3204 || if_pc !== 32'h3200 || fetch_cnt !== 32'd9) begin errs++; $display("FAIL st_once got=%h/%h/%0d exp=3204/3200/9", imem_addr, if_pc, fetch_cnt); end
    endtask

    task automatic test_exc();
        stall = 1'b1; exc_req = 1'b1; eret = 1'b1; epc = 32'h3300;
        step();
        stall = 1'b0; exc_req = 1'b0; eret = 1'b0;
        vec++; if (imem_addr !== 32'h4180 || if_valid !== 1'b0 || fetch_cnt !== 32'd9) begin errs++; $display("FAIL exc_entry got=%h/%b/%0d exp=4180/0/9", imem_addr, if_valid, fetch_cnt); end
        step();
        vec++; if (if_pc !== 32'h4180 || if_valid !== 1'b1 || if_instr !== 32'hA5A5_4180) begin errs++; $display("FAIL exc_fetch got=%h/%b/%h exp=4180/1/a5a54180", if_pc, if_valid, if_instr); end
        vec++; if (imem_addr !== 32'h4184 || fetch_cnt !== 32'd10) begin errs++; $display("FAIL exc_next got=%h/%0d exp=4184/10", imem_addr, fetch_cnt); end
        eret = 1'b1; epc = 32'h3040;
        step();
        eret = 1'b0;
        vec++; if (imem_addr !== 32'h3040 || if_valid !== 1'b0) begin errs++; $display("FAIL eret got=%h/%b exp=3040/0", imem_addr, if_valid); end
        step();
        vec++; if (if_pc !== 32'h3040 || fetch_cnt !== 32'd11) begin errs++; $display("FAIL eret_fetch got=%h/%0d exp=3040/11", if_pc, fetch_cnt); end
    endtask

    task automatic test_fault();
        br_taken = 1'b1; br_target = 32'h5000;
        step();
        vec++; if (fetch_exc !== 1'b0 || imem_addr !== 32'h5000) begin errs++; $display("FAIL flt_pre got=%b/%h exp=0/5000", fetch_exc, imem_addr); end
        br_target = 32'h3002;
        step();
        vec++; if (fetch_exc !== 1'b1 || bad_addr !== 32'h5000 || if_instr !== 32'h0) begin errs++; $display("FAIL flt_high got=%b/%h/%h exp=1/5000/0", fetch_exc, bad_addr, if_instr); end
        vec++; if (if_valid !== 1'b1 || if_pc !== 32'h5000 || imem_addr !== 32'h3002 || fetch_cnt !== 32'd13) begin errs++; $display("FAIL flt_adv got=%b/%h/%h/%0d exp=1/5000/3002/13", if_valid, if_pc, imem_addr, fetch_cnt); end
        br_taken = 1'b0;
        step();
        vec++; if (fetch_exc !== 1'b1 || bad_addr !== 32'h3002 || imem_addr !== 32'h3006) begin errs++; $display("FAIL flt_align got=%b/%h/%h exp=1/3002/3006", fetch_exc, bad_addr, imem_addr); end
        br_taken = 1'b1; br_target = 32'h4FFC;
        step();
        br_taken = 1'b0;
        vec++; if (fetch_exc !== 1'b1 || bad_addr !== 32'h3006) begin errs++; $display("FAIL flt_align2 got=%b/%h exp=1/3006", fetch_exc, bad_addr); end
        step();
        vec++; if (fetch_exc !== 1'b0 || bad_addr !== 32'h3006 || if_instr !== 32'hA5A5_4FFC) begin errs++; $display("FAIL flt_last got=%b/%h/%h exp=0/3006/a5a54ffc", fetch_exc, bad_addr, if_instr); end
        br_taken = 1'b1; br_target = 32'h2FFC;
        step();
        br_taken = 1'b0;
        step();
        vec++; if (fetch_exc !== 1'b1 || bad_addr !== 32'h2FFC || if_instr !== 32'h0) begin errs++; $display("FAIL flt_low got=%b/%h/%h exp=1/2ffc/0", fetch_exc, bad_addr, if_instr); end
    endtask

    task automatic test_reset_hold();
        stall = 1'b1;
        step();
        eret = 1'b1; epc = 32'h3500; br_taken = 1'b1; br_target = 32'h3600; reset = 1'b1;
        step();
        reset = 1'b0; eret = 1'b0; br_taken = 1'b0; stall = 1'b0;
        vec++; if (imem_addr !== 32'h3000 || fetch_cnt !== 32'd0 || if_valid !== 1'b0) begin errs++; $display("FAIL rh_reset got=%h/%0d/%b exp=3000/0/0", imem_addr, fetch_cnt, if_valid); end
        vec++; if (fetch_exc !== 1'b0 || bad_addr !== 32'h0 || if_pc !== 32'h0) begin errs++; $display("FAIL rh_clear got=%b/%h/%h exp=0/0/0", fetch_exc, bad_addr, if_pc); end
        step();
        vec++; if (imem_addr !== 32'h3000 || if_valid !== 1'b0) begin errs++; $display("FAIL rh_boot got=%h/%b exp=3000/0", imem_addr, if_valid); end
        step();
        vec++; if (imem_addr !== 32'h3004 || if_valid !== 1'b1 || fetch_cnt !== 32'd1) begin errs++; $display("FAIL rh_run got=%h/%b/%0d exp=3004/1/1", imem_addr, if_valid, fetch_cnt); end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_branch();
        test_stall();
        test_exc();
        test_fault();
        test_reset_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000: first fetch address after reset.
REQ-002 Parameter EXC_VEC, default 32'h0000_4180: exception handler entry address.
REQ-003 Parameter IM_BASE, default 32'h0000_3000: lowest instruction-memory byte address.
REQ-004 Parameter IM_WORDS, default 2048: instruction-memory depth in 32-bit words.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port stall, input, 1: hazard unit holds the PC and the IF/ID slot.
REQ-008 Ports br_taken, input, 1, and br_target, input, 32: redirect from the ID stage.
REQ-009 Ports exc_req, input, 1, and eret, input, 1, and epc, input, 32: exception entry and return from CP0.
REQ-010 Port imem_addr, output, 32: fetch address driven to the instruction memory.
REQ-011 Port imem_dout, input, 32: instruction word returned combinationally by the instruction memory.
REQ-012 Ports if_pc, output, 32, and if_instr, output, 32, and if_valid, output, 1: registered IF/ID slot.
REQ-013 Ports fetch_exc, output, 1, and bad_addr, output, 32: registered fetch-address fault for the slot.
REQ-014 Port fetch_cnt, output, 32: count of valid fetches delivered.

Function
REQ-015 imem_addr SHALL equal the internal pc register combinationally.
REQ-016 Next-PC priority SHALL be: reset, then exc_req, then eret, then stall, then br_taken, then pc+4.
REQ-017 exc_req SHALL load pc with EXC_VEC and clear if_valid (flush) in the same edge, regardless of stall.
REQ-018 eret without exc_req SHALL load pc with epc and clear if_valid, regardless of stall.
REQ-019 stall SHALL hold pc, if_pc, if_instr, if_valid, fetch_exc, bad_addr and fetch_cnt unchanged.
REQ-020 br_taken without stall SHALL load pc with br_target and keep the concurrently fetched word as the delay slot (no flush).
REQ-021 An unstalled, unflushed edge SHALL load if_pc<=pc, if_instr<=imem_dout and if_valid<=1.
REQ-022 A fetch fault exists when pc[1:0]!=0 or pc<IM_BASE or pc>IM_BASE+4*IM_WORDS-4.
REQ-023 On a faulting fetch: if_instr<=0 (nop), fetch_exc<=1, bad_addr<=pc, if_valid<=1, and pc advances normally.
REQ-024 On a non-faulting fetch, fetch_exc SHALL be 0 and bad_addr SHALL hold its previous value.
REQ-025 The FSM SHALL have states BOOT, RUN and HOLD. BOOT is entered on reset and moves to RUN on the next edge. RUN moves to HOLD on stall. HOLD returns to RUN when stall is low. exc_req or eret forces RUN.
REQ-026 In BOOT, if_valid SHALL be 0 and pc SHALL hold PC_RESET for exactly one cycle.
REQ-027 fetch_cnt SHALL increment by 1 on each edge that sets if_valid<=1, wrapping modulo 2^32.
REQ-028 pc+4 SHALL wrap modulo 2^32 with no fault beyond REQ-022.

Reset
REQ-029 reset SHALL set pc=PC_RESET, state=BOOT, if_pc=0, if_instr=0, if_valid=0, fetch_exc=0, bad_addr=0 and fetch_cnt=0.
REQ-030 reset mid-stall or mid-redirect SHALL override all other inputs on that edge.

Structure
REQ-031 PC_RESET, EXC_VEC, IM_BASE, IM_WORDS and the FSM state encoding SHALL live in shared package cpu_pkg.
REQ-032 The fault check SHALL be a sub-module, fetch_addr_chk (pc in, fault out), combinational.
REQ-033 imem_fetch_ctrl SHALL connect imem_addr/imem_dout directly to im_4k; no other memory port.

Verification
REQ-034 Reset, then 3 free cycles -> imem_addr 0x3000, 0x3000, 0x3004, 0x3008; if_valid 0,0,1,1; fetch_cnt ends at 2.
REQ-035 br_taken=1, br_target=0x3100 at pc=0x3010 -> if_pc=0x3010 valid (delay slot), next imem_addr=0x3100.
REQ-036 stall held 3 cycles at pc=0x3020 with br_taken=1 -> all outputs frozen; after release, redirect applies once.
REQ-037 exc_req and eret together during stall -> pc=0x4180, if_valid=0 next cycle, then fetch from 0x4180.
REQ-038 br_target=0x5000 -> fetch_exc=1, bad_addr=0x5000, if_instr=0; br_target=0x3002 -> fetch_exc=1, bad_addr=0x3002.
REQ-039 reset asserted while in HOLD with eret=1 -> pc=0x3000, state BOOT, fetch_cnt=0.
